// File: rtl/fmem_pkg.sv
// Types and constants shared by the frame-memory write and read controllers.
package fmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FLUSH  = 2'd2
   } wr_state_t;

   localparam int PIX_PER_WORD = 4;
   localparam int TIMING_W     = 11;
   localparam int LANE_W       = $clog2(PIX_PER_WORD);

endpackage

// File: rtl/fmem_write_control_fifo.sv
// Two-entry word buffer between the pixel packer and the frame-memory port.
module word_fifo2 #(
   parameter int WIDTH = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fmem_write_control.sv
// Windowed 24-bpp pixel packer: four pixels per word, buffered writes to frame memory.
// Handshake: a word is written only in a cycle the read side does not own the port (i_busy=0).
module fmem_write_control
   import fmem_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int MEM_WIDTH  = DATA_WIDTH * 4,
   parameter int ADDR_DEPTH = 512 * 512 / 4,
   parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  rst,
   input  logic                  i_vsync,
   input  logic                  i_de,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [TIMING_W-1:0]   i_PSC,
   input  logic [TIMING_W-1:0]   i_PEC,
   input  logic [TIMING_W-1:0]   i_SR,
   input  logic [TIMING_W-1:0]   i_ER,
   input  logic                  i_busy,
   output logic                  o_csn,
   output logic                  o_wen,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [MEM_WIDTH-1:0]  o_wdata,
   output logic                  o_drop,
   output logic                  o_ovf,
   output logic [1:0]            dbg_state
);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_ACTIVE = ACTIVE;
   localparam logic [1:0] S_FLUSH  = FLUSH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

   logic [1:0]            state;
   logic                  vs_d;
   logic                  de_d;
   logic                  vs_rise;
   logic                  de_fall;
   logic                  in_win;
   logic                  accept;
   logic                  last_lane;
   logic [TIMING_W-1:0]   col;
   logic [TIMING_W-1:0]   row;
   logic [LANE_W-1:0]     lane;
   logic [MEM_WIDTH-1:0]  word_reg;
   logic [MEM_WIDTH-1:0]  word_next;
   logic [MEM_WIDTH-1:0]  pend_word;
   logic                  push_pend;
   logic [ADDR_WIDTH-1:0] wptr;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [MEM_WIDTH-1:0]  fifo_dout;

   assign dbg_state = state;
   assign vs_rise   = i_vsync & ~vs_d;
   assign de_fall   = ~i_de & de_d;
   assign in_win    = (col >= i_PSC) && (col <= i_PEC) && (row >= i_SR) && (row <= i_ER);
   assign accept    = (state != S_IDLE) && !vs_rise && i_de && in_win;
   assign last_lane = (lane == LANE_W'(PIX_PER_WORD - 1));
   // Frame restart outranks any push or pop landing on the same edge.
   assign fifo_push = push_pend & ~vs_rise;
   assign fifo_pop  = ~fifo_empty & ~i_busy & ~vs_rise;

   always_comb begin
      word_next = word_reg;
      for (int k = 0; k < PIX_PER_WORD; k++) begin
         if (int'(lane) == k) word_next[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else if (vs_rise) begin
         state <= S_ACTIVE;
      end else begin
         case (state)
            S_ACTIVE, S_FLUSH: state <= (de_fall && lane != '0) ? S_FLUSH : S_ACTIVE;
            default:           state <= state;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (rst) begin
         vs_d      <= 1'b0;
         de_d      <= 1'b0;
         col       <= '0;
         row       <= '0;
         lane      <= '0;
         word_reg  <= '0;
         pend_word <= '0;
         push_pend <= 1'b0;
      end else begin
         vs_d <= i_vsync;
         de_d <= i_de;
         if (vs_rise) begin
            col       <= '0;
            row       <= '0;
            lane      <= '0;
            word_reg  <= '0;
            push_pend <= 1'b0;
         end else begin
            col       <= i_de ? col + 1'b1 : '0;
            push_pend <= 1'b0;
            if (de_fall) row <= row + 1'b1;
            if (accept) begin
               if (last_lane) begin
                  pend_word <= word_next;
                  push_pend <= 1'b1;
                  word_reg  <= '0;
                  lane      <= '0;
               end else begin
                  word_reg <= word_next;
                  lane     <= lane + 1'b1;
               end
            end else if (de_fall && lane != '0 && state != S_IDLE) begin
               // Line ended mid-word: ship it with the unused lanes left at zero.
               pend_word <= word_reg;
               push_pend <= 1'b1;
               word_reg  <= '0;
               lane      <= '0;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (rst) begin
         o_csn   <= 1'b1;
         o_wen   <= 1'b1;
         o_waddr <= '0;
         o_wdata <= '0;
         o_drop  <= 1'b0;
         o_ovf   <= 1'b0;
         wptr    <= '0;
      end else begin
         o_csn <= 1'b1;
         o_wen <= 1'b1;
         if (vs_rise) begin
            wptr  <= '0;
            o_ovf <= 1'b0;
         end else if (fifo_pop) begin
            o_csn   <= 1'b0;
            o_wen   <= 1'b0;
            o_waddr <= wptr;
            o_wdata <= fifo_dout;
            if (wptr == LAST_ADDR) begin
               wptr  <= '0;
               o_ovf <= 1'b1;
            end else begin
               wptr <= wptr + 1'b1;
            end
         end
         if (fifo_push && fifo_full && !fifo_pop) o_drop <= 1'b1;
      end
   end

   word_fifo2 #(
      .WIDTH (MEM_WIDTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (rst),
      .clr   (vs_rise),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (pend_word),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_fmem_write_control.sv
// Bench for fmem_write_control: a full-size instance and a 4-word instance share all inputs.
module tb_fmem_write_control;
   import fmem_pkg::*;

   localparam int DW    = 24;
   localparam int MW    = 96;
   localparam int DEPTH = 512 * 512 / 4;
   localparam int AW    = $clog2(DEPTH);
   localparam int SDEP  = 4;
   localparam int SAW   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_vsync = 1'b0;
   logic          i_de = 1'b0;
   logic          i_busy = 1'b0;
   logic [DW-1:0] i_data = '0;
   logic [10:0]   i_PSC = '0, i_PEC = '0, i_SR = '0, i_ER = '0;

   logic          o_csn, o_wen, o_drop, o_ovf;
   logic [AW-1:0] o_waddr;
   logic [MW-1:0] o_wdata;
   logic [1:0]    dbg_state;
   logic          s_csn, s_wen, s_drop, s_ovf;
   logic [SAW-1:0] s_waddr;
   logic [MW-1:0] s_wdata;
   logic [1:0]    s_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int busy_from = 0, busy_to = 0;
   bit rand_busy = 1'b0;
   bit use_seq   = 1'b0;
   logic [DW-1:0] seq_val = '0;

   logic [AW+MW-1:0]  exp_q[$];
   logic [SAW+MW-1:0] exp_s_q[$];
   logic [AW-1:0]     log_addr[$];
   logic [SAW-1:0]    log_saddr[$];
   logic [MW-1:0]     log_data[$];

   fmem_write_control dut (
      .i_clk(clk), .rst(rst), .i_vsync(i_vsync), .i_de(i_de), .i_data(i_data),
      .i_PSC(i_PSC), .i_PEC(i_PEC), .i_SR(i_SR), .i_ER(i_ER), .i_busy(i_busy),
      .o_csn(o_csn), .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
      .o_drop(o_drop), .o_ovf(o_ovf), .dbg_state(dbg_state)
   );

   fmem_write_control #(.ADDR_DEPTH(SDEP)) dut_small (
      .i_clk(clk), .rst(rst), .i_vsync(i_vsync), .i_de(i_de), .i_data(i_data),
      .i_PSC(i_PSC), .i_PEC(i_PEC), .i_SR(i_SR), .i_ER(i_ER), .i_busy(i_busy),
      .o_csn(s_csn), .o_wen(s_wen), .o_waddr(s_waddr), .o_wdata(s_wdata),
      .o_drop(s_drop), .o_ovf(s_ovf), .dbg_state(s_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected summary");
      $fatal(1, "bench did not finish");
   end

   // ---------------- reference model ----------------
   logic [MW-1:0] m_fifo[$];
   logic [DW-1:0] m_pix[$];
   logic [MW-1:0] m_pend;
   bit m_pend_v, m_idle = 1'b1, m_prev_de, m_prev_vs, m_drop;
   int m_col, m_row, m_wcnt;

   function automatic logic [MW-1:0] pack(input logic [DW-1:0] p[$]);
      logic [MW-1:0] w = '0;
      foreach (p[k]) w[k*DW +: DW] = p[k];
      return w;
   endfunction

   always @(posedge clk) begin
      logic [MW-1:0] w;
      if (rst) begin
         m_fifo.delete(); m_pix.delete();
         m_pend_v = 0; m_idle = 1; m_prev_de = 0; m_prev_vs = 0; m_drop = 0;
         m_col = 0; m_row = 0; m_wcnt = 0;
      end else begin
         if (i_vsync && !m_prev_vs) begin
            m_idle = 0; m_fifo.delete(); m_pix.delete(); m_pend_v = 0;
            m_col = 0; m_row = 0; m_wcnt = 0;
         end else if (!m_idle) begin
            if (m_fifo.size() != 0 && !i_busy) begin
               w = m_fifo.pop_front();
               exp_q.push_back({AW'(m_wcnt % DEPTH), w});
               exp_s_q.push_back({SAW'(m_wcnt % SDEP), w});
               m_wcnt++;
            end
            if (m_pend_v) begin
               if (m_fifo.size() < 2) m_fifo.push_back(m_pend);
               else m_drop = 1;
               m_pend_v = 0;
            end
            if (i_de && m_col >= int'(i_PSC) && m_col <= int'(i_PEC) &&
                m_row >= int'(i_SR) && m_row <= int'(i_ER)) begin
               m_pix.push_back(i_data);
               if (m_pix.size() == 4) begin
                  m_pend = pack(m_pix); m_pend_v = 1; m_pix.delete();
               end
            end else if (!i_de && m_prev_de && m_pix.size() != 0) begin
               m_pend = pack(m_pix); m_pend_v = 1; m_pix.delete();
            end
            if (i_de) m_col++; else m_col = 0;
            if (!i_de && m_prev_de) m_row++;
         end
         m_prev_de = i_de;
         m_prev_vs = i_vsync;
      end
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      logic [AW+MW-1:0]  e;
      logic [SAW+MW-1:0] es;
      if (!o_csn) begin
         log_addr.push_back(o_waddr); log_data.push_back(o_wdata);
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_main: got write %h@%h expected no write", o_wdata, o_waddr);
         end else begin
            e = exp_q.pop_front();
            if ({o_wen, o_waddr, o_wdata} !== {1'b0, e})
               $display("FAIL sb_main: got wen=%b %h expected wen=0 %h", o_wen, {o_waddr, o_wdata}, e);
            else n_pass++;
         end
      end
      if (!s_csn) begin
         log_saddr.push_back(s_waddr);
         n_checks++;
         if (exp_s_q.size() == 0) begin
            $display("FAIL sb_small: got write %h@%h expected no write", s_wdata, s_waddr);
         end else begin
            es = exp_s_q.pop_front();
            if ({s_wen, s_waddr, s_wdata} !== {1'b0, es})
               $display("FAIL sb_small: got wen=%b %h expected wen=0 %h", s_wen, {s_waddr, s_wdata}, es);
            else n_pass++;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(negedge clk);
      cyc++;
      i_busy = ((cyc >= busy_from) && (cyc < busy_to)) || (rand_busy && ($urandom_range(0, 3) == 0));
   endtask

   task automatic pulse_vsync();
      tick(); i_vsync = 1'b1; i_de = 1'b0;
      tick(); i_vsync = 1'b0;
      tick();
   endtask

   task automatic drive_line(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         tick();
         i_de = 1'b1;
         i_data = use_seq ? seq_val : DW'($urandom);
         seq_val++;
      end
      tick(); i_de = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic settle(input int n);
      rand_busy = 1'b0;
      repeat (n) tick();
   endtask

   task automatic set_win(input int psc, input int pec, input int sr, input int er);
      i_PSC = 11'(psc); i_PEC = 11'(pec); i_SR = 11'(sr); i_ER = 11'(er);
   endtask

   task automatic clear_logs();
      log_addr.delete(); log_saddr.delete(); log_data.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_checks++; if (o_csn !== 1'b1) $display("FAIL rst_csn: got %b expected 1", o_csn); else n_pass++;
      n_checks++; if (o_wen !== 1'b1) $display("FAIL rst_wen: got %b expected 1", o_wen); else n_pass++;
      n_checks++; if (o_waddr !== '0) $display("FAIL rst_waddr: got %h expected 0", o_waddr); else n_pass++;
      n_checks++; if (o_wdata !== '0) $display("FAIL rst_wdata: got %h expected 0", o_wdata); else n_pass++;
      n_checks++; if ({o_drop, o_ovf} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {o_drop, o_ovf}); else n_pass++;
      n_checks++; if ({dbg_state, s_state} !== {IDLE, IDLE}) $display("FAIL rst_state: got %h expected 0", {dbg_state, s_state}); else n_pass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      clear_logs();
      set_win(0, 7, 0, 0);
      use_seq = 1'b1; seq_val = 24'd1;
      pulse_vsync();
      drive_line(8, 3);
      drive_line(8, 3);
      settle(10);
      use_seq = 1'b0;
      n_checks++; if (log_data.size() != 2) $display("FAIL basic_count: got %0d expected 2", log_data.size()); else n_pass++;
      n_checks++; if ({log_addr[0], log_data[0]} !== {AW'(0), 96'h000004_000003_000002_000001})
         $display("FAIL basic_w0: got %h expected 0@000004000003000002000001", {log_addr[0], log_data[0]}); else n_pass++;
      n_checks++; if ({log_addr[1], log_data[1]} !== {AW'(1), 96'h000008_000007_000006_000005})
         $display("FAIL basic_w1: got %h expected 1@000008000007000006000005", {log_addr[1], log_data[1]}); else n_pass++;
      n_checks++; if (dbg_state !== ACTIVE) $display("FAIL basic_state: got %0d expected %0d", dbg_state, ACTIVE); else n_pass++;
   endtask

   task automatic test_latency();
      logic [MW-1:0] w = '0;
      set_win(0, 7, 0, 0);
      pulse_vsync();
      for (int i = 0; i < 4; i++) begin
         tick(); i_de = 1'b1; i_data = DW'($urandom); w[i*DW +: DW] = i_data;
      end
      tick(); i_de = 1'b0;
      n_checks++; if (o_csn !== 1'b1) $display("FAIL lat_t0: got csn=%b expected 1", o_csn); else n_pass++;
      tick();
      n_checks++; if (o_csn !== 1'b1) $display("FAIL lat_t1: got csn=%b expected 1", o_csn); else n_pass++;
      tick();
      n_checks++; if ({o_csn, o_wen, o_wdata} !== {2'b00, w})
         $display("FAIL lat_t2: got %b%b %h expected 00 %h", o_csn, o_wen, o_wdata, w); else n_pass++;
      settle(6);
   endtask

   task automatic test_partial();
      clear_logs();
      set_win(2, 4, 0, 1);
      pulse_vsync();
      repeat (3) drive_line(8, 3);
      settle(10);
      n_checks++; if (log_data.size() != 2) $display("FAIL part_count: got %0d expected 2", log_data.size()); else n_pass++;
      n_checks++; if ({log_data[0][95:72], log_data[1][95:72]} !== 48'h0)
         $display("FAIL part_lane3: got %h expected 0", {log_data[0][95:72], log_data[1][95:72]}); else n_pass++;
      n_checks++; if ({log_addr[0], log_addr[1]} !== {AW'(0), AW'(1)})
         $display("FAIL part_addr: got %h %h expected 0 1", log_addr[0], log_addr[1]); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL part_drain: got %0d pending expected 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_vsync_abort();
      logic [MW-1:0] w = '0;
      clear_logs();
      set_win(0, 7, 0, 0);
      pulse_vsync();
      repeat (2) begin tick(); i_de = 1'b1; i_data = DW'($urandom); end
      tick(); i_de = 1'b0; i_vsync = 1'b1;
      tick(); i_vsync = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick(); i_de = 1'b1; i_data = DW'($urandom); w[i*DW +: DW] = i_data;
      end
      tick(); i_de = 1'b0;
      settle(8);
      n_checks++; if (log_data.size() != 1) $display("FAIL abort_count: got %0d expected 1", log_data.size()); else n_pass++;
      n_checks++; if ({log_addr[0], log_data[0]} !== {AW'(0), w})
         $display("FAIL abort_w0: got %h expected %h", {log_addr[0], log_data[0]}, {AW'(0), w}); else n_pass++;
   endtask

   task automatic test_ovf();
      clear_logs();
      set_win(0, 31, 0, 0);
      pulse_vsync();
      drive_line(20, 3);
      settle(12);
      n_checks++; if (log_saddr.size() != 5) $display("FAIL ovf_count: got %0d expected 5", log_saddr.size()); else n_pass++;
      n_checks++; if ({log_saddr[4], log_addr[4]} !== {SAW'(0), AW'(4)})
         $display("FAIL ovf_addr5: got %h %h expected 0 4", log_saddr[4], log_addr[4]); else n_pass++;
      n_checks++; if ({s_ovf, o_ovf} !== 2'b10) $display("FAIL ovf_flag: got %b expected 10", {s_ovf, o_ovf}); else n_pass++;
      pulse_vsync();
      n_checks++; if (s_ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", s_ovf); else n_pass++;
   endtask

   task automatic test_busy();
      clear_logs();
      set_win(0, 31, 0, 0);
      pulse_vsync();
      busy_from = cyc + 1; busy_to = cyc + 15;
      drive_line(12, 3);
      settle(20);
      n_checks++; if (log_data.size() != 2) $display("FAIL busy_count: got %0d expected 2", log_data.size()); else n_pass++;
      n_checks++; if (o_drop !== 1'b1) $display("FAIL busy_drop: got %b expected 1", o_drop); else n_pass++;
      pulse_vsync();
      n_checks++; if (o_drop !== 1'b1) $display("FAIL busy_sticky: got %b expected 1", o_drop); else n_pass++;
   endtask

   task automatic test_random();
      for (int f = 0; f < 5; f++) begin
         set_win($urandom_range(0, 10), $urandom_range(0, 20), $urandom_range(0, 2), $urandom_range(0, 3));
         rand_busy = 1'b1;
         pulse_vsync();
         repeat (4) drive_line($urandom_range(4, 24), $urandom_range(2, 4));
         settle(16);
         n_checks++; if (exp_q.size() + exp_s_q.size() != 0)
            $display("FAIL rand_drain: got %0d pending expected 0", exp_q.size() + exp_s_q.size()); else n_pass++;
         n_checks++; if ({o_drop, s_drop} !== {m_drop, m_drop})
            $display("FAIL rand_drop: got %b%b expected %b%b", o_drop, s_drop, m_drop, m_drop); else n_pass++;
         n_checks++; if ({o_ovf, s_ovf} !== {m_wcnt >= DEPTH, m_wcnt >= SDEP})
            $display("FAIL rand_ovf: got %b%b expected %b%b", o_ovf, s_ovf, m_wcnt >= DEPTH, m_wcnt >= SDEP); else n_pass++;
      end
   endtask

   task automatic test_rst_burst();
      set_win(0, 31, 0, 0);
      pulse_vsync();
      for (int i = 0; i < 16; i++) begin tick(); i_de = 1'b1; i_data = DW'($urandom); end
      tick(); rst = 1'b1; i_data = DW'($urandom);
      tick(); rst = 1'b0;
      n_checks++; if ({o_csn, o_wen, o_drop, o_ovf} !== 4'b1100)
         $display("FAIL rstb_ctrl: got %b expected 1100", {o_csn, o_wen, o_drop, o_ovf}); else n_pass++;
      n_checks++; if ({o_waddr, o_wdata} !== '0) $display("FAIL rstb_data: got %h expected 0", {o_waddr, o_wdata}); else n_pass++;
      clear_logs();
      for (int i = 0; i < 8; i++) begin tick(); i_de = 1'b1; i_data = DW'($urandom); end
      tick(); i_de = 1'b0;
      drive_line(8, 3);
      settle(12);
      n_checks++; if (log_data.size() != 0) $display("FAIL rstb_nowrite: got %0d expected 0", log_data.size()); else n_pass++;
      n_checks++; if (dbg_state !== IDLE) $display("FAIL rstb_state: got %0d expected %0d", dbg_state, IDLE); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_partial();
      test_vsync_abort();
      test_ovf();
      test_busy();
      test_random();
      test_rst_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
